// File: rtl/udma_cfg_pkg.sv
// Shared constants for the uDMA per-peripheral configuration slice:
// register offsets, CFG bit positions, datasize encoding and access FSM states.
package udma_cfg_pkg;

    localparam logic [4:0] REG_RX_SADDR = 5'd0;
    localparam logic [4:0] REG_TX_SADDR = 5'd4;

    // Offsets of the three registers relative to a channel's SADDR
    localparam logic [4:0] OFS_SADDR = 5'd0;
    localparam logic [4:0] OFS_SIZE  = 5'd1;
    localparam logic [4:0] OFS_CFG   = 5'd2;

    localparam int CFG_CONT_BIT  = 0;
    localparam int CFG_DSIZE_LSB = 1;
    localparam int CFG_EN_BIT    = 4;
    localparam int CFG_PEND_BIT  = 5;
    localparam int CFG_CLR_BIT   = 6;
    localparam int CFG_ERR_BIT   = 7;

    typedef enum logic [1:0] {
        DSIZE_BYTE = 2'd0,
        DSIZE_HALF = 2'd1,
        DSIZE_WORD = 2'd2
    } datasize_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } acc_state_e;

    // CLR is write-only, so bit 6 always reads back as zero
    function automatic logic [31:0] cfg_rd_word(input logic       cont,
                                                input logic [1:0] dsize,
                                                input logic       en,
                                                input logic       pend,
                                                input logic       err);
        logic [31:0] w;
        w                         = '0;
        w[CFG_CONT_BIT]           = cont;
        w[CFG_DSIZE_LSB +: 2]     = dsize;
        w[CFG_EN_BIT]             = en;
        w[CFG_PEND_BIT]           = pend;
        w[CFG_ERR_BIT]            = err;
        return w;
    endfunction

endpackage

// File: rtl/udma_cfg_chan.sv
// One uDMA channel's programming registers plus the start/ack handshake,
// clear pulse and sticky start-error flag.
module udma_cfg_chan
    import udma_cfg_pkg::*;
#(
    parameter int L2_AWIDTH_NOAL = 19,
    parameter int TRANS_SIZE     = 20
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      saddr_we_i,
    input  logic                      size_we_i,
    input  logic                      cfg_we_i,
    input  logic [31:0]               wdata_i,
    input  logic                      start_ack_i,
    output logic [L2_AWIDTH_NOAL-1:0] startaddr_o,
    output logic [TRANS_SIZE-1:0]     size_o,
    output logic [1:0]                datasize_o,
    output logic                      continuous_o,
    output logic                      start_o,
    output logic                      clr_o,
    output logic                      start_err_o
);

    logic [L2_AWIDTH_NOAL-1:0] saddr_q, saddr_d;
    logic [TRANS_SIZE-1:0]     size_q, size_d;
    logic [1:0]                dsize_q, dsize_d;
    logic                      cont_q, cont_d;
    logic                      start_q, start_d;
    logic                      clr_q, clr_d;
    logic                      err_q, err_d;

    // Only the low address/size/cfg bits are architecturally meaningful
    logic unused_wdata;
    assign unused_wdata = ^wdata_i;

    always_comb begin
        saddr_d = saddr_q;
        size_d  = size_q;
        dsize_d = dsize_q;
        cont_d  = cont_q;
        start_d = start_q & ~start_ack_i;
        clr_d   = 1'b0;
        err_d   = err_q;

        if (saddr_we_i) saddr_d = wdata_i[L2_AWIDTH_NOAL-1:0];
        if (size_we_i)  size_d  = wdata_i[TRANS_SIZE-1:0];

        if (cfg_we_i) begin
            cont_d  = wdata_i[CFG_CONT_BIT];
            dsize_d = wdata_i[CFG_DSIZE_LSB +: 2];
            if (wdata_i[CFG_ERR_BIT]) err_d = 1'b0;
            // CLR dominates EN; a re-arm while a start is outstanding is only
            // accepted if the channel acknowledges in this very cycle
            if (wdata_i[CFG_CLR_BIT]) begin
                clr_d   = 1'b1;
                start_d = 1'b0;
            end else if (wdata_i[CFG_EN_BIT]) begin
                if (!start_q || start_ack_i) start_d = 1'b1;
                else                         err_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            saddr_q <= '0;
            size_q  <= '0;
            dsize_q <= DSIZE_BYTE;
            cont_q  <= 1'b0;
            start_q <= 1'b0;
            clr_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            saddr_q <= saddr_d;
            size_q  <= size_d;
            dsize_q <= dsize_d;
            cont_q  <= cont_d;
            start_q <= start_d;
            clr_q   <= clr_d;
            err_q   <= err_d;
        end
    end

    assign startaddr_o  = saddr_q;
    assign size_o       = size_q;
    assign datasize_o   = dsize_q;
    assign continuous_o = cont_q;
    assign start_o      = start_q;
    assign clr_o        = clr_q;
    assign start_err_o  = err_q;

endmodule

// File: rtl/udma_periph_cfg_if.sv
// Per-peripheral uDMA configuration slice: fixed-latency access FSM,
// read-back mux and one udma_cfg_chan per direction (index 0 = RX, 1 = TX).
module udma_periph_cfg_if
    import udma_cfg_pkg::*;
#(
    parameter int L2_AWIDTH_NOAL = 19,
    parameter int TRANS_SIZE     = 20
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [31:0]               cfg_data_i,
    input  logic [4:0]                cfg_addr_i,
    input  logic                      cfg_valid_i,
    input  logic                      cfg_rwn_i,
    output logic [31:0]               cfg_data_o,
    output logic                      cfg_ready_o,
    output logic [L2_AWIDTH_NOAL-1:0] rx_startaddr_o,
    output logic [TRANS_SIZE-1:0]     rx_size_o,
    output logic [1:0]                rx_datasize_o,
    output logic                      rx_continuous_o,
    output logic                      rx_start_o,
    input  logic                      rx_start_ack_i,
    output logic                      rx_clr_o,
    input  logic                      rx_busy_i,
    input  logic                      rx_pending_i,
    input  logic [L2_AWIDTH_NOAL-1:0] rx_curr_addr_i,
    input  logic [TRANS_SIZE-1:0]     rx_bytes_left_i,
    output logic [L2_AWIDTH_NOAL-1:0] tx_startaddr_o,
    output logic [TRANS_SIZE-1:0]     tx_size_o,
    output logic [1:0]                tx_datasize_o,
    output logic                      tx_continuous_o,
    output logic                      tx_start_o,
    input  logic                      tx_start_ack_i,
    output logic                      tx_clr_o,
    input  logic                      tx_busy_i,
    input  logic                      tx_pending_i,
    input  logic [L2_AWIDTH_NOAL-1:0] tx_curr_addr_i,
    input  logic [TRANS_SIZE-1:0]     tx_bytes_left_i
);

    acc_state_e  state_q, state_d;
    logic        ready_q, ready_d;
    logic [31:0] rdata_q, rdata_d;
    logic        wr_acc;
    logic [31:0] rd_mux;

    logic [L2_AWIDTH_NOAL-1:0] ch_curr_addr  [2];
    logic [TRANS_SIZE-1:0]     ch_bytes_left [2];
    logic [L2_AWIDTH_NOAL-1:0] ch_startaddr  [2];
    logic [TRANS_SIZE-1:0]     ch_size       [2];
    logic [1:0]                ch_datasize   [2];
    logic [31:0]               ch_rd         [2];
    logic [1:0]                ch_busy, ch_pending, ch_ack;
    logic [1:0]                ch_cont, ch_start, ch_clr, ch_err;

    assign ch_curr_addr[0]  = rx_curr_addr_i;
    assign ch_curr_addr[1]  = tx_curr_addr_i;
    assign ch_bytes_left[0] = rx_bytes_left_i;
    assign ch_bytes_left[1] = tx_bytes_left_i;
    assign ch_busy          = {tx_busy_i, rx_busy_i};
    assign ch_pending       = {tx_pending_i, rx_pending_i};
    assign ch_ack           = {tx_start_ack_i, rx_start_ack_i};

    // Side effects happen only on the IDLE cycle, so a held valid writes once
    assign wr_acc = (state_q == ST_IDLE) && cfg_valid_i && !cfg_rwn_i;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_chan
            localparam logic [4:0] BASE = (gi == 0) ? REG_RX_SADDR : REG_TX_SADDR;

            logic hit_saddr, hit_size, hit_cfg;
            assign hit_saddr = (cfg_addr_i == BASE + OFS_SADDR);
            assign hit_size  = (cfg_addr_i == BASE + OFS_SIZE);
            assign hit_cfg   = (cfg_addr_i == BASE + OFS_CFG);

            assign ch_rd[gi] = hit_saddr ? 32'(ch_curr_addr[gi])  :
                               hit_size  ? 32'(ch_bytes_left[gi]) :
                               hit_cfg   ? cfg_rd_word(ch_cont[gi], ch_datasize[gi],
                                                       ch_start[gi] | ch_busy[gi],
                                                       ch_pending[gi], ch_err[gi]) :
                                           32'd0;

            udma_cfg_chan #(
                .L2_AWIDTH_NOAL (L2_AWIDTH_NOAL),
                .TRANS_SIZE     (TRANS_SIZE)
            ) u_chan (
                .clk_i        (clk_i),
                .rst_i        (rst_i),
                .saddr_we_i   (wr_acc && hit_saddr),
                .size_we_i    (wr_acc && hit_size),
                .cfg_we_i     (wr_acc && hit_cfg),
                .wdata_i      (cfg_data_i),
                .start_ack_i  (ch_ack[gi]),
                .startaddr_o  (ch_startaddr[gi]),
                .size_o       (ch_size[gi]),
                .datasize_o   (ch_datasize[gi]),
                .continuous_o (ch_cont[gi]),
                .start_o      (ch_start[gi]),
                .clr_o        (ch_clr[gi]),
                .start_err_o  (ch_err[gi])
            );
        end
    endgenerate

    assign rd_mux = ch_rd[0] | ch_rd[1];

    always_comb begin
        state_d = state_q;
        ready_d = 1'b0;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (cfg_valid_i) begin
                    state_d = ST_ACK;
                    ready_d = 1'b1;
                    rdata_d = cfg_rwn_i ? rd_mux : 32'd0;
                end
            end
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            rdata_q <= rdata_d;
        end
    end

    assign cfg_ready_o     = ready_q;
    assign cfg_data_o      = rdata_q;

    assign rx_startaddr_o  = ch_startaddr[0];
    assign rx_size_o       = ch_size[0];
    assign rx_datasize_o   = ch_datasize[0];
    assign rx_continuous_o = ch_cont[0];
    assign rx_start_o      = ch_start[0];
    assign rx_clr_o        = ch_clr[0];

    assign tx_startaddr_o  = ch_startaddr[1];
    assign tx_size_o       = ch_size[1];
    assign tx_datasize_o   = ch_datasize[1];
    assign tx_continuous_o = ch_cont[1];
    assign tx_start_o      = ch_start[1];
    assign tx_clr_o        = ch_clr[1];

endmodule
